// File: rtl/seq_detect_moore_p.sv
// Runtime-programmable Moore sequence detector: tracks the longest matched pattern prefix.
// Optional saturating match counter is enabled by defining SEQDET_COUNT_EN.
module seq_detect_moore_p #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = 3'b110,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8,
  localparam int              ST_W    = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             out,
  output logic [ST_W-1:0]  state_o
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_count
`endif
);

  localparam logic [ST_W-1:0] ST_FULL = ST_W'(PAT_W);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [ST_W-1:0]  st_q, st_d;
  logic [ST_W-1:0]  cnt_q, cnt_d;

  logic             accept;
  logic             clear;
  logic [PAT_W-1:0] base_hist;
  logic [PAT_W-1:0] hist_n;
  logic [ST_W-1:0]  base_cnt;
  logic [ST_W-1:0]  cnt_n;
  logic [PAT_W:1]   k_hit;

  // cnt counts accepted bits since the last clear, so prefixes never span stale history.
  always_comb begin
    accept    = in_valid && !pat_load;
    clear     = (OVERLAP == 1'b0) && (st_q == ST_FULL);
    base_hist = clear ? '0 : hist_q;
    base_cnt  = clear ? '0 : cnt_q;
    hist_n    = (base_hist << 1) | {{(PAT_W-1){1'b0}}, in_bit};
    cnt_n     = (base_cnt == ST_FULL) ? ST_FULL : base_cnt + ST_W'(1);
    pat_d     = pat_q;
    hist_d    = hist_q;
    cnt_d     = cnt_q;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      cnt_d  = '0;
    end else if (in_valid) begin
      hist_d = hist_n;
      cnt_d  = cnt_n;
    end
  end

  for (genvar gi = 1; gi <= PAT_W; gi++) begin : g_k
    assign k_hit[gi] = (hist_d[gi-1:0] == pat_q[PAT_W-1:PAT_W-gi]) &&
                       (cnt_d >= ST_W'(gi));
  end

  always_comb begin
    st_d = st_q;
    if (pat_load) begin
      st_d = '0;
    end else if (in_valid) begin
      st_d = '0;
      for (int k = 1; k <= PAT_W; k++) begin
        if (k_hit[k]) st_d = ST_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q  <= PAT_RST;
      hist_q <= '0;
      st_q   <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out     = (st_q == ST_FULL);
  assign state_o = st_q;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  always_comb begin
    mcnt_d = mcnt_q;
    if (accept && (st_d == ST_FULL) && (mcnt_q != {CNT_W{1'b1}})) begin
      mcnt_d = mcnt_q + CNT_W'(1);
    end
  end

  // Cleared by reset only; a pattern reload keeps the running total.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mcnt_q <= '0;
    else        mcnt_q <= mcnt_d;
  end

  assign match_count = mcnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: doc/seq_detect_moore_p.md
# seq_detect_moore_p

Parametrised, runtime-programmable Moore sequence detector; successor to the fixed "110" Moore detector. Samples one serial bit per qualified clock, tracks the longest matched prefix of a programmable pattern, and raises a registered Moore output while the full pattern is matched. Sits on serial bit streams in front of framing and sync logic, and replaces per-pattern hand-coded FSMs.

## Interface
- PAT_W, 3: pattern length N in bits; legal range 2..16.
- PAT_RST, 3'b110: pattern loaded at reset. PAT_RST[N-1] is the first bit expected.
- OVERLAP, 1: 1 means overlapping matches are detected; 0 means detection restarts from empty after a match.
- CNT_W, 8: width of the match counter. Used only when SEQDET_COUNT_EN is defined.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_bit  in  1  serial data bit; sampled only when in_valid=1.
- in_valid  in  1  bit qualifier; when 0, state holds.
- pat_load  in  1  load pat_in into the pattern register.
- pat_in  in  PAT_W  new pattern; MSB is the first bit expected.
- out  out  1  Moore match flag; 1 exactly while state==N.
- state_o  out  clog2(N+1)  current matched-prefix length, for debug.
- match_count  out  CNT_W  saturating match count; present only with SEQDET_COUNT_EN.

## Operation
- Registers:
  - pat: N bits.
  - hist: last N accepted bits, newest in the LSB.
  - st: 0..N.
- st is the number of leading pattern bits matched by the most recent accepted bits.
- On an accepted bit b (in_valid=1, pat_load=0):
  - hist' = {hist[N-2:0], b}.
  - st' = the largest k in 0..N such that hist'[k-1:0] == pat[N-1:N-k], with k bounded by the bits accepted since the last clear.
- OVERLAP=0 and st==N when the bit is accepted: hist and the accepted-bit count are cleared first. st' is then 1 if b==pat[N-1], otherwise 0.
- OVERLAP=1: no clear. A self-overlapping pattern (e.g. 1010) reaches N again after fewer than N further bits.
- out = (st==N). Decoded from the state register only; no combinational path from in_bit.
- pat_load=1:
  - pat <= pat_in; st <= 0; hist and the accepted-bit count are cleared.
  - Any in_bit presented in the same cycle is discarded, even when in_valid=1.
  - pat_load has priority over in_valid.
- in_valid=0 and pat_load=0: all registers hold, so out holds as well.
- Any pat_in value is legal, including all zeros and all ones.

## Timing
- Reset (asynchronous assert, deassert on clk edge):
  - pat=PAT_RST, st=0, hist=0, out=0, state_o=0, match_count=0.
  - Asserting reset mid-stream discards any partial match immediately, without waiting for a clock edge.
- Latency: out rises on the rising edge that samples the final pattern bit, and is visible for the following cycle.
- out falls on the next accepted bit unless that bit completes another overlapping match (OVERLAP=1). In that case out stays high.
- Minimum match spacing is N accepted bits with OVERLAP=0. With OVERLAP=1 it is N minus the longest proper border of the pattern.
- The first match after reset or load requires at least N accepted bits.

## Configuration
- Macro: SEQDET_COUNT_EN.
- Defined:
  - match_count port exists and increments on each accepted bit that drives st' to N.
  - It saturates at 2^CNT_W-1.
  - It clears on reset only; pat_load does not clear it.
- Undefined: no match_count port and no counter logic. All other behaviour is identical.

## Test plan
- Defaults (PAT 110, OVERLAP=1), stream 0,0,1,1,0,0,1,1,0,0,0,1,1,1,0,0 with in_valid=1 -> out high for exactly one cycle after the 5th, 9th and 15th bits; 3 pulses in total.
- pat_load with pat_in=1010, stream 1,0,1,0,1,0,1 -> OVERLAP=1: out after bits 4 and 6. OVERLAP=0: out after bit 4 only.
- Stream 1,1,0 with in_valid dropped for 3 cycles after the final 0 -> out stays 1 for all 4 cycles. The next accepted 1 gives st=1 and out=0.
- Reset pulsed low after bits 1,1 of 110, then 0 applied -> no match; st=0 and out=0 asynchronously.
- pat_load asserted together with in_valid=1 on the bit that would complete a match -> bit discarded, no out pulse, st=0.
- SEQDET_COUNT_EN with CNT_W=2, pattern 11, OVERLAP=1, seven 1s -> match_count goes 1,2,3,3,3,3 after bits 2..7, saturating at 3.
